// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiemon.sv
// Tie-cell monitor: watches a tie-high (A) and tie-low (B) net, filters
// mismatches, and reports a sticky fault plus a saturating fault-event count.
module gf180mcu_osu_sc_gp12t3v3__tiemon #(
  parameter int SETTLE_CYC = 4,
  parameter int FILT       = 2
) (
  input  logic       CLK,
  input  logic       RN,
  input  logic       A,
  input  logic       B,
  input  logic       EN,
  input  logic       CLR,
  output logic       OK,
  output logic       ERR,
  output logic [3:0] ERRCNT,
  output logic [1:0] ST
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    WATCH  = 2'b10,
    FAULT  = 2'b11
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] FILT_LAST   = 4'(FILT - 1);

  state_t     state_q;
  logic       a_meta_q, a_s_q;
  logic       b_meta_q, b_s_q;
  logic [3:0] settle_q;
  logic [3:0] filt_q;
  logic [3:0] errcnt_q;
  logic       ok_q;
  logic       err_q;
  logic       mismatch;

  assign mismatch = (a_s_q != 1'b1) || (b_s_q != 1'b0);

  // OK/ERR are updated on every transition so they always track the state
  // register without a combinational decode on the outputs.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      a_meta_q <= 1'b1;
      a_s_q    <= 1'b1;
      b_meta_q <= 1'b0;
      b_s_q    <= 1'b0;
      state_q  <= IDLE;
      settle_q <= 4'd0;
      filt_q   <= 4'd0;
      errcnt_q <= 4'd0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_meta_q <= A;
      a_s_q    <= a_meta_q;
      b_meta_q <= B;
      b_s_q    <= b_meta_q;

      if (CLR) begin
        errcnt_q <= 4'd0;
      end

      if (!EN) begin
        state_q  <= IDLE;
        settle_q <= 4'd0;
        filt_q   <= 4'd0;
        ok_q     <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= SETTLE;
            settle_q <= 4'd0;
            filt_q   <= 4'd0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
          end
          SETTLE: begin
            filt_q <= 4'd0;
            if (settle_q == SETTLE_LAST) begin
              state_q  <= WATCH;
              settle_q <= 4'd0;
              ok_q     <= 1'b1;
              err_q    <= 1'b0;
            end else begin
              settle_q <= settle_q + 4'd1;
            end
          end
          WATCH: begin
            if (mismatch) begin
              if (filt_q == FILT_LAST) begin
                state_q <= FAULT;
                filt_q  <= 4'd0;
                ok_q    <= 1'b0;
                err_q   <= 1'b1;
                // A coincident CLR wins over the increment.
                if (!CLR && errcnt_q != 4'd15) begin
                  errcnt_q <= errcnt_q + 4'd1;
                end
              end else begin
                filt_q <= filt_q + 4'd1;
              end
            end else begin
              filt_q <= 4'd0;
            end
          end
          FAULT: begin
            filt_q <= 4'd0;
            if (CLR) begin
              state_q  <= SETTLE;
              settle_q <= 4'd0;
              ok_q     <= 1'b0;
              err_q    <= 1'b0;
            end
          end
          default: begin
            state_q  <= IDLE;
            settle_q <= 4'd0;
            filt_q   <= 4'd0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign OK     = ok_q;
  assign ERR    = err_q;
  assign ERRCNT = errcnt_q;
  assign ST     = state_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tiemon.sv
// Directed bench for the tie monitor (default SETTLE_CYC=4, FILT=2).
module tb_gf180mcu_osu_sc_gp12t3v3__tiemon;

  logic       clk = 1'b0;
  logic       rn  = 1'b0;
  logic       a   = 1'b1;
  logic       b   = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic       ok;
  logic       err;
  logic [3:0] errcnt;
  logic [1:0] st;

  int checks = 0;
  int errors = 0;

  gf180mcu_osu_sc_gp12t3v3__tiemon dut (
    .CLK    (clk),
    .RN     (rn),
    .A      (a),
    .B      (b),
    .EN     (en),
    .CLR    (clr),
    .OK     (ok),
    .ERR    (err),
    .ERRCNT (errcnt),
    .ST     (st)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rn = 1'b0; en = 1'b0; a = 1'b1; b = 1'b0; clr = 1'b0;
    tick(); tick();
    checks++;
    if ({ok, err, errcnt, st} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ok=%b err=%b cnt=%0d st=%b want all 0", ok, err, errcnt, st);
    end
    $display("test_reset done");
  endtask

  // Scenario 1: four SETTLE cycles then WATCH.
  task automatic test_settle();
    en = 1'b1;
    rn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (st !== 2'b01 || ok !== 1'b0) begin
        errors++;
        $display("FAIL settle_cycle%0d got st=%b ok=%b want st=01 ok=0", i, st, ok);
      end
    end
    tick();
    checks++;
    if (st !== 2'b10 || ok !== 1'b1 || err !== 1'b0 || errcnt !== 4'd0) begin
      errors++;
      $display("FAIL settle_to_watch got st=%b ok=%b err=%b cnt=%0d want 10/1/0/0", st, ok, err, errcnt);
    end
    $display("test_settle done");
  endtask

  // Scenario 3: single-cycle glitch is filtered out.
  task automatic test_glitch();
    a = 1'b0;
    tick();
    a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (st !== 2'b10 || ok !== 1'b1 || errcnt !== 4'd0) begin
        errors++;
        $display("FAIL glitch_cycle%0d got st=%b ok=%b cnt=%0d want 10/1/0", i, st, ok, errcnt);
      end
    end
    $display("test_glitch done");
  endtask

  // Scenario 2: persistent A=0 faults after edge k+3.
  task automatic test_fault_latency();
    a = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (st !== 2'b10 || ok !== 1'b1) begin
      errors++;
      $display("FAIL fault_early got st=%b ok=%b want 10/1 after edge k+2", st, ok);
    end
    tick();
    checks++;
    if (st !== 2'b11 || err !== 1'b1 || ok !== 1'b0 || errcnt !== 4'd1) begin
      errors++;
      $display("FAIL fault_entry got st=%b err=%b ok=%b cnt=%0d want 11/1/0/1", st, err, ok, errcnt);
    end
    // B toggling while faulted must change nothing.
    b = 1'b1;
    tick(); tick(); tick(); tick();
    b = 1'b0;
    checks++;
    if (st !== 2'b11 || errcnt !== 4'd1) begin
      errors++;
      $display("FAIL fault_sticky got st=%b cnt=%0d want 11/1", st, errcnt);
    end
    $display("test_fault_latency done");
  endtask

  // Scenario 4: CLR exits FAULT to SETTLE and clears the count.
  task automatic test_clear();
    a = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (st !== 2'b01 || errcnt !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL clear_exit got st=%b cnt=%0d err=%b want 01/0/0", st, errcnt, err);
    end
    tick(); tick(); tick();
    checks++;
    if (st !== 2'b01) begin
      errors++;
      $display("FAIL clear_settle got st=%b want 01", st);
    end
    tick();
    checks++;
    if (st !== 2'b10 || ok !== 1'b1) begin
      errors++;
      $display("FAIL clear_rewatch got st=%b ok=%b want 10/1", st, ok);
    end
    // CLR while in WATCH leaves the state alone.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (st !== 2'b10 || ok !== 1'b1) begin
      errors++;
      $display("FAIL clear_in_watch got st=%b ok=%b want 10/1", st, ok);
    end
    $display("test_clear done");
  endtask

  // Fault increment coinciding with CLR: FAULT entered, count becomes 0.
  task automatic test_clr_coincide();
    a = 1'b0;
    tick(); tick();
    a = 1'b1;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (st !== 2'b11 || err !== 1'b1 || errcnt !== 4'd0) begin
      errors++;
      $display("FAIL clr_coincide got st=%b err=%b cnt=%0d want 11/1/0", st, err, errcnt);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (st !== 2'b10) begin
      errors++;
      $display("FAIL clr_coincide_rewatch got st=%b want 10", st);
    end
    $display("test_clr_coincide done");
  endtask

  // Scenario 5: 17 faults via EN toggle saturate the count at 15.
  task automatic test_saturate();
    logic [3:0] exp_cnt;
    for (int i = 1; i <= 17; i++) begin
      exp_cnt = (i > 15) ? 4'd15 : 4'(i);
      a = 1'b0;
      tick(); tick(); tick(); tick();
      checks++;
      if (st !== 2'b11 || errcnt !== exp_cnt) begin
        errors++;
        $display("FAIL sat_fault%0d got st=%b cnt=%0d want 11/%0d", i, st, errcnt, exp_cnt);
      end
      a = 1'b1;
      en = 1'b0;
      tick();
      checks++;
      if (st !== 2'b00 || errcnt !== exp_cnt || err !== 1'b0) begin
        errors++;
        $display("FAIL sat_idle%0d got st=%b cnt=%0d err=%b want 00/%0d/0", i, st, errcnt, err, exp_cnt);
      end
      if (i < 17) begin
        en = 1'b1;
        for (int j = 0; j < 5; j++) tick();
        checks++;
        if (st !== 2'b10) begin
          errors++;
          $display("FAIL sat_rewatch%0d got st=%b want 10", i, st);
        end
      end
      $display("saturate fault %0d cnt=%0d", i, errcnt);
    end
  endtask

  // Scenario 6: reset mid-filter discards progress immediately.
  task automatic test_reset_midfilter();
    en = 1'b1;
    for (int j = 0; j < 5; j++) tick();
    checks++;
    if (st !== 2'b10 || errcnt !== 4'd15) begin
      errors++;
      $display("FAIL rst_pre got st=%b cnt=%0d want 10/15", st, errcnt);
    end
    b = 1'b1;
    tick(); tick(); tick();
    #2;
    rn = 1'b0;
    #1;
    checks++;
    if ({ok, err, errcnt, st} !== 8'h00) begin
      errors++;
      $display("FAIL rst_async got ok=%b err=%b cnt=%0d st=%b want all 0", ok, err, errcnt, st);
    end
    tick();
    b = 1'b0;
    rn = 1'b1;
    tick();
    checks++;
    if (st !== 2'b01 || errcnt !== 4'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart got st=%b cnt=%0d err=%b want 01/0/0", st, errcnt, err);
    end
    for (int j = 0; j < 4; j++) tick();
    checks++;
    if (st !== 2'b10 || err !== 1'b0 || errcnt !== 4'd0) begin
      errors++;
      $display("FAIL rst_rewatch got st=%b err=%b cnt=%0d want 10/0/0", st, err, errcnt);
    end
    $display("test_reset_midfilter done");
  endtask

  initial begin
    test_reset();
    test_settle();
    test_glitch();
    test_fault_latency();
    test_clear();
    test_clr_coincide();
    test_saturate();
    test_reset_midfilter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
